iomem_copy_initiator: RTL and testbench

- Bus-initiator engine that drives the iomem valid/ready interface from the master side.
- Copies a block of 32-bit words from a source address to a destination address: word read, then word write, repeated.
- Shares the memory-side bus with the processor through an external mux. Used to preload/relocate program images and for bench-side bus stimulus.
- Obeys the same handshake the memory responder (RAM with programmable ready delay, timer registers) expects.

---
 rtl/iomem_copy_initiator_if.sv | 25 ++
 rtl/iomem_copy_initiator.sv | 206 ++++++++++++++++++++
 tb/tb_iomem_copy_initiator.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iomem_copy_initiator_if.sv
// iomem valid/ready bus bundle shared by a bus initiator and a memory responder.
//   iomem_valid : request valid (initiator -> responder)
//   iomem_ready : request completion, may be combinational on valid
//   iomem_wstrb : 4'hF write, 4'h0 read
//   iomem_addr  : word-aligned byte address
//   iomem_wdata : write data
//   iomem_rdata : read data, valid in the handshake cycle
interface iomem_copy_initiator_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_copy_initiator.sv
// Word copy engine mastering the iomem bus: read word i from src, write it to
// dst, repeat for len words, with a one-cycle valid-low gap after every
// handshake. Optional per-request ready timeout aborts with a sticky error.
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   start_i            : start pulse (ignored while busy_o)
//   src_addr_i         : source byte address (bits [1:0] forced 0)
//   dst_addr_i         : destination byte address (bits [1:0] forced 0)
//   len_words_i        : word count
//   abort_i            : stop after the current write handshake
//   busy_o             : transfer in progress
//   done_o             : one-cycle pulse at transfer end
//   err_o              : sticky timeout flag, cleared by next accepted start
//   words_done_o       : words written so far
//   bus                : iomem master port
module iomem_copy_initiator #(
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [31:0]           src_addr_i,
  input  logic [31:0]           dst_addr_i,
  input  logic [LEN_W-1:0]      len_words_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [LEN_W-1:0]      words_done_o,
  iomem_copy_initiator_if.master bus
);

  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_GAP_W, S_WR, S_GAP_R, S_FIN
  } state_t;

  state_t           r_state, w_state_d;
  logic             r_valid, w_valid_d;
  logic [3:0]       r_wstrb, w_wstrb_d;
  logic [31:0]      r_addr,  w_addr_d;
  logic [31:0]      r_wdata, w_wdata_d;
  logic             r_busy,  w_busy_d;
  logic             r_done,  w_done_d;
  logic             r_err,   w_err_d;
  logic [LEN_W-1:0] r_words, w_words_d;
  logic [LEN_W-1:0] r_len,   w_len_d;
  logic [31:0]      r_src,   w_src_d;
  logic [31:0]      r_dst,   w_dst_d;
  logic             r_abort, w_abort_d;
  logic [TO_W-1:0]  r_tcnt,  w_tcnt_d;

  logic             w_hs;
  logic             w_to;
  logic [LEN_W-1:0] w_words_inc;

  assign w_hs        = r_valid & bus.iomem_ready;
  assign w_to        = (TIMEOUT_CYCLES != 0) && r_valid && !bus.iomem_ready &&
                       (r_tcnt == TO_W'(TO_LAST));
  assign w_words_inc = r_words + LEN_W'(1);

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_wstrb <= 4'h0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_words <= '0;
      r_len   <= '0;
      r_src   <= 32'h0;
      r_dst   <= 32'h0;
      r_abort <= 1'b0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_d;
      r_valid <= w_valid_d;
      r_wstrb <= w_wstrb_d;
      r_addr  <= w_addr_d;
      r_wdata <= w_wdata_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
      r_words <= w_words_d;
      r_len   <= w_len_d;
      r_src   <= w_src_d;
      r_dst   <= w_dst_d;
      r_abort <= w_abort_d;
      r_tcnt  <= w_tcnt_d;
    end
  end

  // Next-state and next-output logic; bus outputs change only on state transitions
  always_comb begin
    w_state_d = r_state;
    w_valid_d = r_valid;
    w_wstrb_d = r_wstrb;
    w_addr_d  = r_addr;
    w_wdata_d = r_wdata;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;
    w_err_d   = r_err;
    w_words_d = r_words;
    w_len_d   = r_len;
    w_src_d   = r_src;
    w_dst_d   = r_dst;
    w_abort_d = r_abort;
    w_tcnt_d  = r_tcnt;

    // Abort request is remembered until the current write handshake
    if (r_busy && abort_i) w_abort_d = 1'b1;
    // Wait counter runs only while a request is stalled
    if (r_valid && !bus.iomem_ready) w_tcnt_d = r_tcnt + TO_W'(1);

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (len_words_i == '0) begin
            w_done_d = 1'b1;
          end else begin
            w_src_d   = src_addr_i & 32'hFFFF_FFFC;
            w_dst_d   = dst_addr_i & 32'hFFFF_FFFC;
            w_len_d   = len_words_i;
            w_err_d   = 1'b0;
            w_words_d = '0;
            w_abort_d = 1'b0;
            w_busy_d  = 1'b1;
            w_valid_d = 1'b1;
            w_wstrb_d = 4'h0;
            w_addr_d  = src_addr_i & 32'hFFFF_FFFC;
            w_tcnt_d  = '0;
            w_state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (w_to) begin
          w_valid_d = 1'b0;
          w_err_d   = 1'b1;
          w_busy_d  = 1'b0;
          w_state_d = S_FIN;
        end else if (w_hs) begin
          w_wdata_d = bus.iomem_rdata;
          w_valid_d = 1'b0;
          w_state_d = S_GAP_W;
        end
      end
      S_GAP_W: begin
        w_valid_d = 1'b1;
        w_wstrb_d = 4'hF;
        w_addr_d  = r_dst;
        w_tcnt_d  = '0;
        w_state_d = S_WR;
      end
      S_WR: begin
        if (w_to) begin
          w_valid_d = 1'b0;
          w_wstrb_d = 4'h0;
          w_err_d   = 1'b1;
          w_busy_d  = 1'b0;
          w_state_d = S_FIN;
        end else if (w_hs) begin
          w_words_d = w_words_inc;
          w_src_d   = r_src + 32'd4;
          w_dst_d   = r_dst + 32'd4;
          w_valid_d = 1'b0;
          w_wstrb_d = 4'h0;
          if ((w_words_inc == r_len) || r_abort || abort_i) begin
            w_busy_d  = 1'b0;
            w_state_d = S_FIN;
          end else begin
            w_state_d = S_GAP_R;
          end
        end
      end
      S_GAP_R: begin
        w_valid_d = 1'b1;
        w_wstrb_d = 4'h0;
        w_addr_d  = r_src;
        w_tcnt_d  = '0;
        w_state_d = S_RD;
      end
      S_FIN: begin
        w_done_d  = 1'b1;
        w_state_d = S_IDLE;
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  assign bus.iomem_valid = r_valid;
  assign bus.iomem_wstrb = r_wstrb;
  assign bus.iomem_addr  = r_addr;
  assign bus.iomem_wdata = r_wdata;
  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign err_o           = r_err;
  assign words_done_o    = r_words;

endmodule

// File: tb/tb_iomem_copy_initiator.sv
// Scoreboard bench for iomem_copy_initiator: expected bus transactions and
// completions are queued by the stimulus; a monitor pops and compares them as
// the DUT presents handshakes and done pulses.
module tb_iomem_copy_initiator;

  localparam int unsigned LEN_W = 16;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [LEN_W-1:0] words;
    logic             err;
  } done_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      src = 32'h0;
  logic [31:0]      dst = 32'h0;
  logic [LEN_W-1:0] len = '0;
  logic             abort = 1'b0;
  logic             busy, done, err;
  logic [LEN_W-1:0] words_done;

  int               n_vec = 0;
  int               n_miss = 0;

  txn_t             exp_q[$];
  done_t            done_q[$];

  // Responder model
  int               delay = 0;
  logic             never = 1'b0;
  int               wcnt;
  logic [31:0]      mem [0:63];

  iomem_copy_initiator_if bus ();

  iomem_copy_initiator #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .src_addr_i   (src),
    .dst_addr_i   (dst),
    .len_words_i  (len),
    .abort_i      (abort),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .words_done_o (words_done),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] map_addr(input logic [31:0] a);
    if (a[31:12] == 20'h40000) return {2'b00, a[5:2]};
    if (a[31:12] == 20'h40001) return {2'b01, a[5:2]};
    if (a == 32'hFFFF_FFFC) return 6'd32;
    if (a == 32'h0000_0000) return 6'd33;
    return 6'd63;
  endfunction

  assign bus.iomem_ready = bus.iomem_valid && !never && (wcnt == delay);
  assign bus.iomem_rdata = mem[map_addr(bus.iomem_addr)];

  always @(posedge clk) begin
    if (rst) begin
      wcnt <= 0;
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0]  <= 32'h11;
      mem[1]  <= 32'h22;
      mem[2]  <= 32'h33;
      mem[3]  <= 32'h44;
      mem[32] <= 32'hAAAA_0001;
      mem[33] <= 32'hAAAA_0002;
    end else begin
      if (!bus.iomem_valid || bus.iomem_ready) wcnt <= 0;
      else wcnt <= wcnt + 1;
      if (bus.iomem_valid && bus.iomem_ready && bus.iomem_wstrb == 4'hF)
        mem[map_addr(bus.iomem_addr)] <= bus.iomem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_rd(input logic [31:0] a);
    exp_q.push_back('{wr: 1'b0, addr: a, data: 32'h0});
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{wr: 1'b1, addr: a, data: d});
  endtask

  task automatic exp_done(input logic [LEN_W-1:0] w, input logic e);
    done_q.push_back('{words: w, err: e});
  endtask

  // Returns after the edge that samples start (cycle 1 begins there)
  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d,
                            input logic [LEN_W-1:0] n, input logic ab);
    @(negedge clk);
    src = s; dst = d; len = n; start = 1'b1; abort = ab;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
  endtask

  // Cycle number (edges since start sampled, first = 1) at which done_o is seen
  task automatic wait_done(output int k);
    k = 1;
    forever begin
      @(negedge clk);
      if (done) return;
      if (k > 3000) begin
        n_vec++; n_miss++;
        $display("FAIL done_timeout: got no done_o expected pulse within 3000 cycles");
        return;
      end
      @(posedge clk);
      k++;
    end
  endtask

  task automatic monitor();
    logic        pv;
    logic        phs;
    logic [31:0] pa;
    logic [31:0] pd;
    logic [3:0]  ps;
    txn_t        e;
    done_t       d;
    pv = 1'b0; phs = 1'b0; pa = 32'h0; pd = 32'h0; ps = 4'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0; phs = 1'b0;
        continue;
      end
      if (phs) chk("gap_after_handshake", {31'b0, bus.iomem_valid}, 32'h0);
      if (bus.iomem_valid && pv && !phs) begin
        chk("addr_stable", bus.iomem_addr, pa);
        chk("wstrb_stable", {28'b0, bus.iomem_wstrb}, {28'b0, ps});
        chk("wdata_stable", bus.iomem_wdata, pd);
      end
      if (bus.iomem_valid && bus.iomem_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_txn: got addr %h wstrb %h expected no transaction",
                   bus.iomem_addr, bus.iomem_wstrb);
        end else begin
          e = exp_q.pop_front();
          chk("txn_wstrb", {28'b0, bus.iomem_wstrb}, e.wr ? 32'hF : 32'h0);
          chk("txn_addr", bus.iomem_addr, e.addr);
          if (e.wr) chk("txn_wdata", bus.iomem_wdata, e.data);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_done: got done_o=1 expected no pulse");
        end else begin
          d = done_q.pop_front();
          chk("done_words", 32'(words_done), 32'(d.words));
          chk("done_err", {31'b0, err}, {31'b0, d.err});
        end
      end
      pv  = bus.iomem_valid;
      phs = bus.iomem_valid && bus.iomem_ready;
      pa  = bus.iomem_addr;
      pd  = bus.iomem_wdata;
      ps  = bus.iomem_wstrb;
    end
  endtask

  initial begin
    int k;
    int nv;
    int guard;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, bus.iomem_valid}, 32'h0);
    chk("rst_wstrb", {28'b0, bus.iomem_wstrb}, 32'h0);
    chk("rst_addr", bus.iomem_addr, 32'h0);
    chk("rst_wdata", bus.iomem_wdata, 32'h0);
    chk("rst_flags", {29'b0, busy, done, err}, 32'h0);
    chk("rst_words", 32'(words_done), 32'h0);
    rst = 1'b0;

    // Zero-wait copy of three words
    exp_rd(32'h4000_0000); exp_wr(32'h4000_1000, 32'h11);
    exp_rd(32'h4000_0004); exp_wr(32'h4000_1004, 32'h22);
    exp_rd(32'h4000_0008); exp_wr(32'h4000_1008, 32'h33);
    exp_done(16'd3, 1'b0);
    start_xfer(32'h4000_0000, 32'h4000_1000, 16'd3, 1'b0);
    wait_done(k);
    chk("zw_done_cycle", 32'(k), 32'd13);
    chk("zw_mem0", mem[16], 32'h11);
    chk("zw_mem1", mem[17], 32'h22);
    chk("zw_mem2", mem[18], 32'h33);

    // Delayed responder: each phase lasts delay+1 cycles (7 wait cycles stay under the 8-cycle timeout)
    delay = 7;
    exp_rd(32'h4000_0004); exp_wr(32'h4000_1010, 32'h22);
    exp_rd(32'h4000_0008); exp_wr(32'h4000_1014, 32'h33);
    exp_done(16'd2, 1'b0);
    start_xfer(32'h4000_0006, 32'h4000_1012, 16'd2, 1'b0);
    wait_done(k);
    chk("dl_done_cycle", 32'(k), 32'd37);
    chk("dl_mem0", mem[20], 32'h22);
    chk("dl_mem1", mem[21], 32'h33);
    delay = 0;

    // Zero length: done next cycle, no bus activity, words_done unchanged
    exp_done(16'd2, 1'b0);
    start_xfer(32'h4000_0000, 32'h4000_1000, 16'd0, 1'b0);
    @(negedge clk);
    chk("len0_busy", {31'b0, busy}, 32'h0);
    chk("len0_valid", {31'b0, bus.iomem_valid}, 32'h0);
    chk("len0_done", {31'b0, done}, 32'h1);
    @(negedge clk);
    chk("len0_done_clear", {31'b0, done}, 32'h0);

    // Abort during the read of word 1 of 4
    exp_rd(32'h4000_0000); exp_wr(32'h4000_1020, 32'h11);
    exp_rd(32'h4000_0004); exp_wr(32'h4000_1024, 32'h22);
    exp_done(16'd2, 1'b0);
    start_xfer(32'h4000_0000, 32'h4000_1020, 16'd4, 1'b0);
    guard = 0;
    forever begin
      @(negedge clk);
      if (bus.iomem_valid && bus.iomem_wstrb == 4'h0 && bus.iomem_addr == 32'h4000_0004) break;
      guard++;
      if (guard > 100) begin
        n_vec++; n_miss++;
        $display("FAIL abort_wait: got no read of word 1 expected within 100 cycles");
        break;
      end
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_done(k);
    chk("ab_mem1", mem[25], 32'h22);
    chk("ab_mem2", mem[26], 32'h0);

    // Responder never ready: valid held exactly 8 cycles, then error
    never = 1'b1;
    exp_done(16'd0, 1'b1);
    start_xfer(32'h4000_0000, 32'h4000_1030, 16'd1, 1'b0);
    nv = 0;
    guard = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (bus.iomem_valid) nv++;
      guard++;
      if (guard > 100) begin
        n_vec++; n_miss++;
        $display("FAIL to_wait: got no done_o expected within 100 cycles");
        break;
      end
    end
    chk("to_valid_cycles", 32'(nv), 32'd8);
    @(negedge clk);
    chk("to_err_sticky", {31'b0, err}, 32'h1);
    never = 1'b0;

    // Next start clears the error and copies normally
    exp_rd(32'h4000_0000); exp_wr(32'h4000_1030, 32'h11);
    exp_done(16'd1, 1'b0);
    start_xfer(32'h4000_0000, 32'h4000_1030, 16'd1, 1'b0);
    @(negedge clk);
    chk("to_err_cleared", {31'b0, err}, 32'h0);
    wait_done(k);
    chk("to_mem", mem[28], 32'h11);

    // Asynchronous reset in the middle of a write
    delay = 5;
    exp_rd(32'h4000_0000);
    start_xfer(32'h4000_0000, 32'h4000_1038, 16'd2, 1'b0);
    guard = 0;
    forever begin
      @(negedge clk);
      if (bus.iomem_valid && bus.iomem_wstrb == 4'hF) break;
      guard++;
      if (guard > 100) begin
        n_vec++; n_miss++;
        $display("FAIL rst_wait: got no write request expected within 100 cycles");
        break;
      end
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, bus.iomem_valid}, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_wstrb", {28'b0, bus.iomem_wstrb}, 32'h0);
    chk("arst_addr", bus.iomem_addr, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("arst_pending_txn", 32'(exp_q.size()), 32'h0);
    rst = 1'b0;
    delay = 0;

    // Address wrap; abort coincident with start in IDLE is ignored
    exp_rd(32'hFFFF_FFFC); exp_wr(32'h4000_1000, 32'hAAAA_0001);
    exp_rd(32'h0000_0000); exp_wr(32'h4000_1004, 32'hAAAA_0002);
    exp_done(16'd2, 1'b0);
    start_xfer(32'hFFFF_FFFC, 32'h4000_1000, 16'd2, 1'b1);
    wait_done(k);
    chk("wrap_done_cycle", 32'(k), 32'd9);
    chk("wrap_mem0", mem[16], 32'hAAAA_0001);
    chk("wrap_mem1", mem[17], 32'hAAAA_0002);

    repeat (3) @(negedge clk);
    chk("final_txn_q", 32'(exp_q.size()), 32'h0);
    chk("final_done_q", 32'(done_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
